alu_issue_stage: RTL and testbench

16-bit execute-issue pipeline register that sits directly upstream of the ALU. It accepts decoded instructions from decode, selects and forwards operands, and detects load-use hazards, inserting one bubble when needed. It presents registered `OutA`/`OutB`/`OutALUOp` to the ALU under a valid/ready handshake. Branch resolution can flush it.

---
 rtl/alu_issue_stage.sv | 138 +++++++++++++
 tb/tb_alu_issue_stage.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// Execute-issue pipeline register feeding the ALU: operand forwarding,
// load-use bubble insertion and a valid/ready handshake toward the ALU.
module alu_issue_stage #(
    parameter int DATA_W  = 16,
    parameter int REG_AW  = 4,
    parameter int STALL_W = 16
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               InValid,
    output logic               InReady,
    input  logic [2:0]         InALUOp,
    input  logic [REG_AW-1:0]  InRs1,
    input  logic [REG_AW-1:0]  InRs2,
    input  logic [REG_AW-1:0]  InRd,
    input  logic               InRegWrite,
    input  logic               InIsLoad,
    input  logic               InUseImm,
    input  logic [DATA_W-1:0]  InImm,
    input  logic [DATA_W-1:0]  InRs1Data,
    input  logic [DATA_W-1:0]  InRs2Data,
    input  logic               FwdExValid,
    input  logic [REG_AW-1:0]  FwdExRd,
    input  logic [DATA_W-1:0]  FwdExData,
    input  logic               FwdWbValid,
    input  logic [REG_AW-1:0]  FwdWbRd,
    input  logic [DATA_W-1:0]  FwdWbData,
    input  logic               Flush,
    input  logic               OutReady,
    output logic               OutValid,
    output logic [DATA_W-1:0]  OutA,
    output logic [DATA_W-1:0]  OutB,
    output logic [2:0]         OutALUOp,
    output logic [REG_AW-1:0]  OutRd,
    output logic               OutRegWrite,
    output logic               OutIsLoad,
    output logic [STALL_W-1:0] StallCount
);

    typedef enum logic {RUN, BUBBLE} state_t;

    state_t            state, state_nxt;
    logic              last_load;
    logic              hazard;
    logic              do_bubble;
    logic              do_xfer;
    logic [DATA_W-1:0] opnd_a, opnd_rs2, opnd_b;

    // r0 is hard zero; the EX result is younger than WB, so it wins.
    function automatic logic [DATA_W-1:0] sel_opnd(
        input logic [REG_AW-1:0] rs,
        input logic [DATA_W-1:0] rf_data,
        input logic              ex_vld,
        input logic [REG_AW-1:0] ex_rd,
        input logic [DATA_W-1:0] ex_data,
        input logic              wb_vld,
        input logic [REG_AW-1:0] wb_rd,
        input logic [DATA_W-1:0] wb_data
    );
        if (rs == '0)                      return '0;
        else if (ex_vld && (ex_rd == rs))  return ex_data;
        else if (wb_vld && (wb_rd == rs))  return wb_data;
        else                               return rf_data;
    endfunction

    assign opnd_a   = sel_opnd(InRs1, InRs1Data, FwdExValid, FwdExRd, FwdExData,
                               FwdWbValid, FwdWbRd, FwdWbData);
    assign opnd_rs2 = sel_opnd(InRs2, InRs2Data, FwdExValid, FwdExRd, FwdExData,
                               FwdWbValid, FwdWbRd, FwdWbData);
    assign opnd_b   = InUseImm ? InImm : opnd_rs2;

    // The output register doubles as the last-issued record; a bubble or
    // flush clears OutValid, which also clears the hazard source.
    assign last_load = OutValid & OutIsLoad & OutRegWrite;
    assign hazard    = InValid & last_load & (OutRd != '0) &
                       ((OutRd == InRs1) | (~InUseImm & (OutRd == InRs2)));
    assign InReady   = OutReady & ~hazard & ~Flush;
    assign do_xfer   = InValid & InReady;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= RUN;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        do_bubble = 1'b0;
        case (state)
            RUN: begin
                if (hazard && OutReady && !Flush) begin
                    do_bubble = 1'b1;
                    state_nxt = BUBBLE;
                end
            end
            BUBBLE:  state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
        if (Flush) state_nxt = RUN;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            OutValid    <= 1'b0;
            OutA        <= '0;
            OutB        <= '0;
            OutALUOp    <= '0;
            OutRd       <= '0;
            OutRegWrite <= 1'b0;
            OutIsLoad   <= 1'b0;
            StallCount  <= '0;
        end else if (Flush) begin
            OutValid    <= 1'b0;
            OutRd       <= '0;
            OutRegWrite <= 1'b0;
            OutIsLoad   <= 1'b0;
        end else if (OutReady) begin
            if (do_bubble) begin
                OutValid    <= 1'b0;
                OutALUOp    <= '0;
                OutRd       <= '0;
                OutRegWrite <= 1'b0;
                OutIsLoad   <= 1'b0;
                if (StallCount != '1) StallCount <= StallCount + 1'b1;
            end else if (do_xfer) begin
                OutValid    <= 1'b1;
                OutA        <= opnd_a;
                OutB        <= opnd_b;
                OutALUOp    <= InALUOp;
                OutRd       <= InRd;
                OutRegWrite <= InRegWrite;
                OutIsLoad   <= InIsLoad;
            end else begin
                OutValid    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: stimulus pushes expected ALU operand
// sets into a queue, a negedge monitor pops them as the ALU consumes them.
module tb_alu_issue_stage;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        InValid, InReady;
    logic [2:0]  InALUOp;
    logic [3:0]  InRs1, InRs2, InRd;
    logic        InRegWrite, InIsLoad, InUseImm;
    logic [15:0] InImm, InRs1Data, InRs2Data;
    logic        FwdExValid, FwdWbValid;
    logic [3:0]  FwdExRd, FwdWbRd;
    logic [15:0] FwdExData, FwdWbData;
    logic        Flush, OutReady, OutValid;
    logic [15:0] OutA, OutB;
    logic [2:0]  OutALUOp;
    logic [3:0]  OutRd;
    logic        OutRegWrite, OutIsLoad;
    logic [15:0] StallCount;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  op;
        logic [3:0]  rd;
        logic        rw;
        logic        ld;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    alu_issue_stage #(.DATA_W(16), .REG_AW(4), .STALL_W(16)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .InValid(InValid), .InReady(InReady), .InALUOp(InALUOp),
        .InRs1(InRs1), .InRs2(InRs2), .InRd(InRd),
        .InRegWrite(InRegWrite), .InIsLoad(InIsLoad), .InUseImm(InUseImm),
        .InImm(InImm), .InRs1Data(InRs1Data), .InRs2Data(InRs2Data),
        .FwdExValid(FwdExValid), .FwdExRd(FwdExRd), .FwdExData(FwdExData),
        .FwdWbValid(FwdWbValid), .FwdWbRd(FwdWbRd), .FwdWbData(FwdWbData),
        .Flush(Flush), .OutReady(OutReady), .OutValid(OutValid),
        .OutA(OutA), .OutB(OutB), .OutALUOp(OutALUOp), .OutRd(OutRd),
        .OutRegWrite(OutRegWrite), .OutIsLoad(OutIsLoad), .StallCount(StallCount)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drv(input logic [2:0] op, input logic [3:0] rs1, input logic [3:0] rs2,
                       input logic [3:0] rd, input logic rw, input logic ld,
                       input logic ui, input logic [15:0] imm,
                       input logic [15:0] d1, input logic [15:0] d2);
        InValid = 1'b1; InALUOp = op; InRs1 = rs1; InRs2 = rs2; InRd = rd;
        InRegWrite = rw; InIsLoad = ld; InUseImm = ui; InImm = imm;
        InRs1Data = d1; InRs2Data = d2;
    endtask

    task automatic push(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                        input logic [3:0] rd, input logic rw, input logic ld);
        exp_t e;
        e.a = a; e.b = b; e.op = op; e.rd = rd; e.rw = rw; e.ld = ld;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // The ALU takes an operand set at each edge where OutValid & OutReady.
    always @(negedge CLK) begin
        if (RST_N && OutValid && OutReady) begin
            if (q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_out: got OutA=%0h OutB=%0h expected no output", OutA, OutB);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("OutA", {16'h0, OutA}, {16'h0, e.a});
                check("OutB", {16'h0, OutB}, {16'h0, e.b});
                check("OutALUOp", {29'h0, OutALUOp}, {29'h0, e.op});
                check("OutCtl", {26'h0, OutRd, OutRegWrite, OutIsLoad},
                      {26'h0, e.rd, e.rw, e.ld});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        RST_N = 1'b0; OutReady = 1'b1; Flush = 1'b0;
        InValid = 1'b0; InALUOp = '0; InRs1 = '0; InRs2 = '0; InRd = '0;
        InRegWrite = 1'b0; InIsLoad = 1'b0; InUseImm = 1'b0; InImm = '0;
        InRs1Data = '0; InRs2Data = '0;
        FwdExValid = 1'b0; FwdExRd = '0; FwdExData = '0;
        FwdWbValid = 1'b0; FwdWbRd = '0; FwdWbData = '0;
        #2;
        check("rst_OutValid", {31'h0, OutValid}, 32'h0);
        check("rst_OutA", {16'h0, OutA}, 32'h0);
        check("rst_OutB", {16'h0, OutB}, 32'h0);
        check("rst_Stall", {16'h0, StallCount}, 32'h0);
        check("rst_InReady", {31'h0, InReady}, 32'h1);
        #6 RST_N = 1'b1;

        // ADD r3 <= r1 + r2
        drv(3'd0, 4'd1, 4'd2, 4'd3, 1, 0, 0, 16'h0, 16'h0005, 16'h0007);
        push(16'h0005, 16'h0007, 3'd0, 4'd3, 1, 0);
        #1 check("add_InReady", {31'h0, InReady}, 32'h1);
        step();

        // EX and WB both forward r1; r2 slot reads r0
        drv(3'd0, 4'd1, 4'd0, 4'd7, 1, 0, 0, 16'h0, 16'hAAAA, 16'hBBBB);
        FwdExValid = 1'b1; FwdExRd = 4'd1; FwdExData = 16'h1111;
        FwdWbValid = 1'b1; FwdWbRd = 4'd1; FwdWbData = 16'h2222;
        push(16'h1111, 16'h0000, 3'd0, 4'd7, 1, 0);
        step();
        FwdExValid = 1'b0; FwdWbValid = 1'b0;

        // LOAD r4, then SUB r5 <= r4 - r1 must stall one cycle
        drv(3'd0, 4'd2, 4'd0, 4'd4, 1, 1, 1, 16'h0010, 16'h0100, 16'h0);
        push(16'h0100, 16'h0010, 3'd0, 4'd4, 1, 1);
        step();
        drv(3'd1, 4'd4, 4'd1, 4'd5, 1, 0, 0, 16'h0, 16'h9999, 16'h0003);
        #1 check("lu_InReady", {31'h0, InReady}, 32'h0);
        step();
        check("bubble_OutValid", {31'h0, OutValid}, 32'h0);
        check("bubble_Stall", {16'h0, StallCount}, 32'h1);
        FwdWbValid = 1'b1; FwdWbRd = 4'd4; FwdWbData = 16'h4444;
        push(16'h4444, 16'h0003, 3'd1, 4'd5, 1, 0);
        #1 check("retry_InReady", {31'h0, InReady}, 32'h1);
        step();
        FwdWbValid = 1'b0;

        // LOAD r4, then ADDI with InRs2=4 ignored: no stall
        drv(3'd0, 4'd2, 4'd0, 4'd4, 1, 1, 1, 16'h0000, 16'h0200, 16'h0);
        push(16'h0200, 16'h0000, 3'd0, 4'd4, 1, 1);
        step();
        drv(3'd0, 4'd2, 4'd4, 4'd6, 1, 0, 1, 16'hFFFF, 16'h0002, 16'h5555);
        push(16'h0002, 16'hFFFF, 3'd0, 4'd6, 1, 0);
        #1 check("addi_InReady", {31'h0, InReady}, 32'h1);
        step();
        check("addi_Stall", {16'h0, StallCount}, 32'h1);

        // ALU backpressure for 3 cycles with a pending instruction
        drv(3'd2, 4'd1, 4'd2, 4'd8, 1, 0, 0, 16'h0, 16'h0011, 16'h0022);
        OutReady = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("hold_InReady", {31'h0, InReady}, 32'h0);
            check("hold_OutA", {16'h0, OutA}, 32'h0002);
            check("hold_OutB", {16'h0, OutB}, 32'hFFFF);
            check("hold_OutValid", {31'h0, OutValid}, 32'h1);
            step();
        end
        OutReady = 1'b1;
        push(16'h0011, 16'h0022, 3'd2, 4'd8, 1, 0);
        #1 check("release_InReady", {31'h0, InReady}, 32'h1);
        step();

        // Flush while a load is issued and a dependent op is pending
        drv(3'd0, 4'd0, 4'd0, 4'd9, 1, 1, 1, 16'h0009, 16'h0, 16'h0);
        push(16'h0000, 16'h0009, 3'd0, 4'd9, 1, 1);
        step();
        drv(3'd1, 4'd9, 4'd0, 4'd10, 1, 0, 0, 16'h0, 16'h0123, 16'h0);
        Flush = 1'b1;
        #1 check("flush_InReady", {31'h0, InReady}, 32'h0);
        step();
        Flush = 1'b0;
        check("flush_OutValid", {31'h0, OutValid}, 32'h0);
        check("flush_Stall", {16'h0, StallCount}, 32'h1);
        push(16'h0123, 16'h0000, 3'd1, 4'd10, 1, 0);
        #1 check("postflush_InReady", {31'h0, InReady}, 32'h1);
        step();

        // Async reset mid-stream with a live, held output
        drv(3'd3, 4'd1, 4'd2, 4'd11, 1, 0, 0, 16'h0, 16'h00AB, 16'h00CD);
        step();
        InValid = 1'b0; OutReady = 1'b0;
        #1 check("prerst_OutValid", {31'h0, OutValid}, 32'h1);
        #1 RST_N = 1'b0;
        #1;
        check("arst_OutValid", {31'h0, OutValid}, 32'h0);
        check("arst_OutA", {16'h0, OutA}, 32'h0);
        check("arst_OutB", {16'h0, OutB}, 32'h0);
        check("arst_OutCtl", {24'h0, OutALUOp, OutRd, OutRegWrite}, 32'h0);
        check("arst_Stall", {16'h0, StallCount}, 32'h0);
        check("arst_InReady", {31'h0, InReady}, 32'h0);
        check("queue_empty", q.size(), 32'h0);
        step();
        RST_N = 1'b1;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
